// File: rtl/flash_reader_if.sv
// flash_reader_if -- signal bundle between the boot loader, flash_reader and
// the x16 NOR flash device.
//
// Loader side : flashCs, flashAddr (requests) / flashReady, flashData (result)
// Flash side  : flashBusAddr, flashCeN, flashOeN, flashWeN, flashRpN,
//               flashByteN (controls) / flashBusDq (read data)
//
// Modports:
//   slave  -- the reader itself (takes requests, drives the flash pins)
//   master -- the environment (loader plus flash device)
interface flash_reader_if;
  logic        flashCs;
  logic [24:0] flashAddr;
  logic        flashReady;
  logic [31:0] flashData;
  logic [25:0] flashBusAddr;
  logic [15:0] flashBusDq;
  logic        flashCeN;
  logic        flashOeN;
  logic        flashWeN;
  logic        flashRpN;
  logic        flashByteN;

  modport slave (
    input  flashCs, flashAddr, flashBusDq,
    output flashReady, flashData, flashBusAddr,
           flashCeN, flashOeN, flashWeN, flashRpN, flashByteN
  );

  modport master (
    output flashCs, flashAddr, flashBusDq,
    input  flashReady, flashData, flashBusAddr,
           flashCeN, flashOeN, flashWeN, flashRpN, flashByteN
  );
endinterface

// File: rtl/flash_reader.sv
// flash_reader -- reads 32-bit words from an x16 NOR flash as two half-word
// accesses (low half first, little-endian) for a boot loader.
//
// Ports:
//   clk  -- single clock, rising edge
//   rst  -- synchronous active-high reset
//   bus  -- flash_reader_if.slave: loader request/result handshake and the
//           NOR flash pins
//
// Parameter:
//   WAIT_CYCLES -- access cycles per half-word and power-up hold (2..255)
//
// After reset the flash is held in power-down for one cycle, then released,
// and the reader waits WAIT_CYCLES edges before reporting ready. A request
// is only taken when flashCs has been seen low since the previous one, so a
// loader that leaves flashCs high across completion gets a single read.
module flash_reader #(
  parameter int WAIT_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  flash_reader_if.slave bus
);

  if (WAIT_CYCLES < 2 || WAIT_CYCLES > 255) begin : gBadWait
    $error("flash_reader: WAIT_CYCLES must be in 2..255");
  end

  localparam logic [7:0] CNT_LOAD = 8'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    STARTUP,
    IDLE,
    READ_LO,
    READ_HI,
    RECOVER
  } stateT;

  stateT       state,      stateNext;
  logic [7:0]  cnt,        cntNext;
  logic        armed,      armedNext;
  logic [24:0] addrLat,    addrLatNext;
  logic [31:0] shadow,     shadowNext;
  logic        readyR,     readyNext;
  logic [31:0] dataR,      dataNext;
  logic [25:0] busAddrR,   busAddrNext;
  logic        ceNR,       ceNNext;
  logic        oeNR,       oeNNext;
  logic        rpNR,       rpNNext;

  logic        accept;

  assign accept = (state == IDLE) && bus.flashCs && readyR && armed;

  // Next-state and next-output logic. Every register holds by default; the
  // case only lists what changes.
  always_comb begin
    stateNext   = state;
    cntNext     = cnt;
    armedNext   = armed;
    addrLatNext = addrLat;
    shadowNext  = shadow;
    readyNext   = readyR;
    dataNext    = dataR;
    busAddrNext = busAddrR;
    ceNNext     = ceNR;
    oeNNext     = oeNR;
    rpNNext     = rpNR;

    // Any edge that sees the request line low re-arms acceptance.
    if (!bus.flashCs) begin
      armedNext = 1'b1;
    end

    case (state)
      STARTUP: begin
        // Power-down is released on the first edge out of reset; the
        // countdown gives the device its wake-up time.
        rpNNext = 1'b1;
        if (cnt == 8'd0) begin
          stateNext = IDLE;
          readyNext = 1'b1;
        end else begin
          cntNext = cnt - 8'd1;
        end
      end

      IDLE: begin
        if (accept) begin
          // The word address is latched here so later flashAddr activity
          // cannot disturb the second half-word access.
          addrLatNext = bus.flashAddr;
          readyNext   = 1'b0;
          armedNext   = 1'b0;
          busAddrNext = {bus.flashAddr, 1'b0};
          ceNNext     = 1'b0;
          oeNNext     = 1'b0;
          cntNext     = CNT_LOAD;
          stateNext   = READ_LO;
        end
      end

      READ_LO: begin
        if (cnt == 8'd0) begin
          shadowNext[15:0] = bus.flashBusDq;
          busAddrNext      = {addrLat, 1'b1};
          cntNext          = CNT_LOAD;
          stateNext        = READ_HI;
        end else begin
          cntNext = cnt - 8'd1;
        end
      end

      READ_HI: begin
        if (cnt == 8'd0) begin
          shadowNext[31:16] = bus.flashBusDq;
          ceNNext           = 1'b1;
          oeNNext           = 1'b1;
          stateNext         = RECOVER;
        end else begin
          cntNext = cnt - 8'd1;
        end
      end

      RECOVER: begin
        // One bus-idle cycle before the word is published, so the device
        // sees CE/OE high between back-to-back reads.
        dataNext  = shadow;
        readyNext = 1'b1;
        stateNext = IDLE;
      end

      default: begin
        stateNext = STARTUP;
        cntNext   = CNT_LOAD;
        readyNext = 1'b0;
        ceNNext   = 1'b1;
        oeNNext   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= STARTUP;
      cnt      <= CNT_LOAD;
      armed    <= 1'b0;
      addrLat  <= '0;
      shadow   <= '0;
      readyR   <= 1'b0;
      dataR    <= '0;
      busAddrR <= '0;
      ceNR     <= 1'b1;
      oeNR     <= 1'b1;
      rpNR     <= 1'b0;
    end else begin
      state    <= stateNext;
      cnt      <= cntNext;
      armed    <= armedNext;
      addrLat  <= addrLatNext;
      shadow   <= shadowNext;
      readyR   <= readyNext;
      dataR    <= dataNext;
      busAddrR <= busAddrNext;
      ceNR     <= ceNNext;
      oeNR     <= oeNNext;
      rpNR     <= rpNNext;
    end
  end

  assign bus.flashReady   = readyR;
  assign bus.flashData    = dataR;
  assign bus.flashBusAddr = busAddrR;
  assign bus.flashCeN     = ceNR;
  assign bus.flashOeN     = oeNR;
  assign bus.flashRpN     = rpNR;
  // Read-only, x16 device: write strobe and byte mode are tied inactive.
  assign bus.flashWeN     = 1'b1;
  assign bus.flashByteN   = 1'b1;

endmodule

// File: tb/tb_flash_reader.sv
// Bench for flash_reader: a loader process issues requests and queues the
// expected word and acceptance cycle; a monitor process checks bus activity
// and completions against the queue head every cycle.
module tb_flash_reader;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  bit   monEn = 1'b0;

  typedef struct {
    logic [24:0] addr;
    logic [31:0] data;
    int          accept;
  } reqT;

  reqT q[$];

  flash_reader_if bus();

  flash_reader #(.WAIT_CYCLES(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Flash contents: two fixed half-words plus a scrambled pattern elsewhere.
  function automatic logic [15:0] mem(input logic [25:0] a);
    if (a == 26'd6) return 16'h5678;
    if (a == 26'd7) return 16'h1234;
    return 16'(a[15:0] * 16'h9E37) ^ a[25:10] ^ 16'h3C5A;
  endfunction

  // Reference: word w occupies half-words 2w (low) and 2w+1 (high).
  function automatic logic [31:0] refWord(input logic [24:0] w);
    logic [25:0] h;
    h = 26'(w) * 26'd2;
    return {mem(h + 26'd1), mem(h)};
  endfunction

  // The device only drives the bus when both CE and OE are asserted.
  assign bus.flashBusDq = (!bus.flashCeN && !bus.flashOeN) ? mem(bus.flashBusAddr) : 16'hDEAD;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: runs just after every rising edge.
  initial begin : monitor
    logic [31:0] lastData;
    bit prevEn;
    int ph;
    lastData = '0;
    prevEn = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (monEn) begin
        if (!prevEn) lastData = '0;
        if (q.size() > 0 && cyc >= q[0].accept) begin
          ph = cyc - q[0].accept;
          if (ph < 2 * W) begin
            check("busAddr", 32'(bus.flashBusAddr),
                  32'({q[0].addr, 1'b0}) + ((ph >= W) ? 32'd1 : 32'd0));
            check("ceOeActive", {30'd0, bus.flashCeN, bus.flashOeN}, 32'd0);
            check("readyBusy", 32'(bus.flashReady), 32'd0);
            check("dataHeld", bus.flashData, lastData);
          end else if (ph == 2 * W) begin
            check("ceOeRecover", {30'd0, bus.flashCeN, bus.flashOeN}, 32'd3);
            check("readyRecover", 32'(bus.flashReady), 32'd0);
            check("dataHeld", bus.flashData, lastData);
          end else begin
            check("readyDone", 32'(bus.flashReady), 32'd1);
            check("readData", bus.flashData, q[0].data);
            lastData = q[0].data;
            void'(q.pop_front());
          end
        end else begin
          check("idlePins", {27'd0, bus.flashCeN, bus.flashOeN, bus.flashWeN,
                             bus.flashByteN, bus.flashRpN}, 32'h1F);
          check("readyIdle", 32'(bus.flashReady), 32'd1);
          check("dataIdle", bus.flashData, lastData);
        end
      end
      prevEn = monEn;
    end
  end

  task automatic waitReady();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.flashReady && q.size() == 0) && n < 300);
    check("readyTimeout", 32'(bus.flashReady && q.size() == 0), 32'd1);
  endtask

  // Issue one request, hold flashCs for 'hold' edges while scrambling the
  // address after the first edge, then drop it.
  task automatic doRead(input logic [24:0] a, input int hold, input logic [31:0] exp);
    waitReady();
    bus.flashCs   = 1'b1;
    bus.flashAddr = a;
    q.push_back('{addr: a, data: exp, accept: cyc + 1});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      bus.flashAddr = 25'($urandom);
    end
    bus.flashCs = 1'b0;
  endtask

  // Release reset and check the power-up wait.
  task automatic startupCheck();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= W; k++) begin
      @(posedge clk);
      #1;
      check("startupReady", 32'(bus.flashReady), (k == W) ? 32'd1 : 32'd0);
      check("startupRpN", 32'(bus.flashRpN), 32'd1);
      check("startupCeOe", {30'd0, bus.flashCeN, bus.flashOeN}, 32'd3);
      check("startupData", bus.flashData, 32'd0);
    end
    monEn = 1'b1;
  endtask

  task automatic resetValues();
    check("rstReady", 32'(bus.flashReady), 32'd0);
    check("rstData", bus.flashData, 32'd0);
    check("rstBusAddr", 32'(bus.flashBusAddr), 32'd0);
    check("rstPins", {27'd0, bus.flashCeN, bus.flashOeN, bus.flashWeN,
                      bus.flashByteN, bus.flashRpN}, 32'h1E);
  endtask

  initial begin : stim
    int start;
    logic [24:0] a;
    bus.flashCs   = 1'b0;
    bus.flashAddr = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    resetValues();
    startupCheck();

    // Directed word at address 3, flashCs held two cycles.
    doRead(25'd3, 2, 32'h12345678);
    check("refWord3", refWord(25'd3), 32'h12345678);

    // Loader-style back-to-back sequence.
    for (int i = 0; i < 4; i++) doRead(25'(i), 1, refWord(25'(i)));

    // flashCs held high well past completion: one read only.
    doRead(25'h00ABCDE, 40, refWord(25'h00ABCDE));
    doRead(25'h0000010, 1, refWord(25'h0000010));

    // Top of the address space, address scrambled during the read.
    doRead(25'h1FFFFFF, 3, refWord(25'h1FFFFFF));

    // Randomised requests with random hold and gaps.
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      a = 25'($urandom);
      if (i % 5 == 0) a = 25'($urandom_range(0, 15));
      doRead(a, $urandom_range(1, 3), refWord(a));
    end

    // Reset in the middle of a read.
    waitReady();
    bus.flashCs   = 1'b1;
    bus.flashAddr = 25'h0123456;
    start = cyc + 1;
    q.push_back('{addr: 25'h0123456, data: refWord(25'h0123456), accept: start});
    repeat (5) @(negedge clk);
    monEn = 1'b0;
    q.delete();
    rst = 1'b1;
    bus.flashCs = 1'b0;
    @(posedge clk);
    #1;
    check("abortCycle", 32'(cyc - start), 32'd5);
    resetValues();
    startupCheck();

    // Normal operation after the abort.
    doRead(25'd7, 1, refWord(25'd7));
    waitReady();
    repeat (5) @(negedge clk);

    monEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule

// File: doc/flash_reader.md
FLASH_READER -- requirements
Module: flash_reader

Interface
REQ-001 Parameter: WAIT_CYCLES, 8, access cycles per half-word read and power-up hold cycles; legal range 2..255.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 flashCs  input  1  read request from loader.
REQ-005 flashAddr  input  25  32-bit word address of request.
REQ-006 flashReady  output  1  high = idle, flashData valid, request may be issued.
REQ-007 flashData  output  32  last completed read word.
REQ-008 flashBusAddr  output  26  half-word address to NOR flash = {word address, half select}.
REQ-009 flashBusDq  input  16  NOR flash data bus (read-only use).
REQ-010 flashCeN  output  1  chip enable, active-low.
REQ-011 flashOeN  output  1  output enable, active-low.
REQ-012 flashWeN  output  1  write enable, held 1 at all times (never written).
REQ-013 flashRpN  output  1  flash reset/power-down, active-low.
REQ-014 flashByteN  output  1  held 1 at all times (x16 mode).

Function
REQ-015 States SHALL be STARTUP, IDLE, READ_LO, READ_HI, RECOVER; 8-bit wait counter.
REQ-016 STARTUP: flashRpN=1, flashReady=0, bus idle; after WAIT_CYCLES edges -> IDLE with flashReady=1.
REQ-017 Acceptance: at an edge with state IDLE, flashCs=1, flashReady=1 and armed=1 -> latch flashAddr, flashReady<=0, armed<=0, flashBusAddr<={flashAddr,0}, flashCeN<=0, flashOeN<=0, counter<=WAIT_CYCLES-1, -> READ_LO.
REQ-018 armed SHALL set at any edge sampling flashCs=0; a flashCs held high across completion SHALL NOT start a second read.
REQ-019 flashCs while not IDLE SHALL be ignored and flashAddr changes SHALL NOT affect an accepted read.
REQ-020 READ_LO: counter decrements each edge; at edge with counter=0 capture flashBusDq into shadow[15:0], flashBusAddr<={addr,1}, counter<=WAIT_CYCLES-1, -> READ_HI.
REQ-021 READ_HI: same countdown; at counter=0 capture flashBusDq into shadow[31:16], flashCeN<=1, flashOeN<=1, -> RECOVER.
REQ-022 RECOVER: one cycle; next edge flashData<={captured hi, shadow lo}, flashReady<=1, -> IDLE.
REQ-023 Latency: acceptance at edge E0 -> flashReady=1 and flashData valid after edge E0+2*WAIT_CYCLES+1 (E0+17 at default).
REQ-024 flashReady SHALL fall at the acceptance edge, so a loader sampling it two edges after raising flashCs sees 0.
REQ-025 flashData SHALL change only at the completion edge and hold until the next completion.
REQ-026 Word order: low half-word (even address) = flashData[15:0], little-endian.
REQ-027 flashBusAddr SHALL be stable for the full WAIT_CYCLES window before each capture.
REQ-028 flashAddr 0x1FFFFFF SHALL map to half-word addresses 0x3FFFFFE/0x3FFFFFF with no wrap into other words.
REQ-029 flashCeN/flashOeN SHALL be 1 in STARTUP, IDLE and RECOVER.

Reset
REQ-030 At rst=1 edge: state STARTUP, flashReady=0, flashData=0, flashBusAddr=0, flashCeN=1, flashOeN=1, flashRpN=0, flashWeN=1, flashByteN=1, counter=WAIT_CYCLES-1, armed=0, shadow=0.
REQ-031 rst mid-read SHALL abort with no completion, bus released at that edge, STARTUP re-run before flashReady returns to 1.

Verification
REQ-032 Reset release, flashCs=0 -> flashReady 0 for 8 edges then 1; flashRpN=1 from first non-reset edge.
REQ-033 flashCs=1 two cycles, flashAddr=3, flash model returns 0x5678 at 6, 0x1234 at 7 -> flashBusAddr 6 then 7, flashReady=1 at E0+17, flashData=0x12345678.
REQ-034 Loader-style sequence addr 0,1,2,3 back-to-back -> four completions, each flashData matches model, no extra reads.
REQ-035 flashCs held 1 for 40 cycles -> exactly one read; second read only after flashCs sampled 0.
REQ-036 rst asserted at E0+5 -> flashCeN/flashOeN=1 next edge, flashData=0, flashReady stays 0 for 8 edges after release.
REQ-037 flashAddr=0x1FFFFFF -> flashBusAddr 0x3FFFFFE then 0x3FFFFFF; flashAddr toggled during read has no effect.
